// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam int HDR_WIDTH      = 16;
  localparam int BYTES_PER_WORD = 4;

  // States in which the loader accepts bytes and reports busy.
  function automatic logic is_rx_state(state_e s);
    return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_PAYLOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/loader_word_pack.sv
// Packs accepted payload bytes into little-endian words and keeps the running XOR.
module loader_word_pack
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic [7:0]  xor_o
);

  localparam int              CntW    = $clog2(BYTES_PER_WORD);
  localparam logic [CntW-1:0] LastCnt = CntW'(BYTES_PER_WORD - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     word_q, word_d;
  logic [7:0]      xor_q, xor_d;
  logic            word_valid_q, word_valid_d;

  always_comb begin
    cnt_d        = cnt_q;
    word_d       = word_q;
    xor_d        = xor_q;
    word_valid_d = 1'b0;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
      xor_d  = '0;
    end else if (byte_valid_i) begin
      cnt_d        = cnt_q + 1'b1;
      // Shift right so the first byte of a word ends up in bits [7:0].
      word_d       = {byte_i, word_q[31:8]};
      xor_d        = xor_q ^ byte_i;
      word_valid_d = (cnt_q == LastCnt);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      word_q       <= '0;
      xor_q        <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      xor_q        <= xor_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign last_byte_o  = (cnt_q == LastCnt);
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;
  assign xor_o        = xor_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes instruction memory, checks the
// XOR checksum and releases the core only after a clean load.
//
// state      | meaning
// IDLE       | after reset, waiting for start
// HDR_LO     | waiting for word count bits [7:0]
// HDR_HI     | waiting for word count bits [15:8]
// PAYLOAD    | receiving payload bytes, one write per 4 bytes
// CHECK      | waiting for the checksum byte
// DONE       | load good, core released
// ERROR      | oversize frame or bad checksum, core held
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic                  core_reset_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [15:0]           words_loaded_o
);

  localparam logic [HDR_WIDTH-1:0] MaxN = HDR_WIDTH'(MAX_WORDS);

  state_e               state_q, state_d;
  logic [7:0]           n_lo_q, n_lo_d;
  logic [HDR_WIDTH-1:0] n_q, n_d;
  logic [15:0]          words_loaded_q;
  logic                 rx_ready_q, busy_q, done_q, error_q, core_reset_n_q;
  logic                 clear, xfer, payload_byte;
  logic                 last_byte, word_valid;
  logic [31:0]          word;
  logic [7:0]           xor_sum;

  assign xfer         = rx_valid_i && rx_ready_q;
  assign payload_byte = xfer && (state_q == ST_PAYLOAD);

  loader_word_pack u_pack (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear),
    .byte_valid_i (payload_byte),
    .byte_i       (rx_data_i),
    .last_byte_o  (last_byte),
    .word_valid_o (word_valid),
    .word_o       (word),
    .xor_o        (xor_sum)
  );

  always_comb begin
    state_d = state_q;
    n_lo_d  = n_lo_q;
    n_d     = n_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_i) begin
          state_d = ST_HDR_LO;
          n_d     = '0;
          clear   = 1'b1;
        end
      end
      ST_HDR_LO: begin
        if (xfer) begin
          n_lo_d  = rx_data_i;
          state_d = ST_HDR_HI;
        end
      end
      ST_HDR_HI: begin
        if (xfer) begin
          n_d = {rx_data_i, n_lo_q};
          if (n_d > MaxN)      state_d = ST_ERROR;
          else if (n_d == '0)  state_d = ST_CHECK;
          else                 state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        // Last byte of the last word: the checksum may arrive while its write pulses.
        if (payload_byte && last_byte && (words_loaded_q == n_q - HDR_WIDTH'(1)))
          state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (xfer) state_d = (rx_data_i == xor_sum) ? ST_DONE : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      n_lo_q         <= '0;
      n_q            <= '0;
      words_loaded_q <= '0;
      rx_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      core_reset_n_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_lo_q         <= n_lo_d;
      n_q            <= n_d;
      if (clear)           words_loaded_q <= '0;
      else if (word_valid) words_loaded_q <= words_loaded_q + 16'd1;
      rx_ready_q     <= is_rx_state(state_d);
      busy_q         <= is_rx_state(state_d);
      done_q         <= (state_d == ST_DONE);
      error_q        <= (state_d == ST_ERROR);
      core_reset_n_q <= (state_d == ST_DONE);
    end
  end

  assign rx_ready_o     = rx_ready_q;
  assign imem_we_o      = word_valid;
  assign imem_addr_o    = words_loaded_q[ADDR_WIDTH-1:0];
  assign imem_wdata_o   = word;
  assign core_reset_n_o = core_reset_n_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = words_loaded_q;

endmodule
